// File: rtl/axi4_stream_to_full.sv
// AXI4-Stream slave to AXI4 memory-mapped write master: splits a beat count into INCR bursts.
// One FSM runs AW, then W (stream passed straight through), then B, strictly in sequence.
module axi4_stream_to_full #(
  parameter int C_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_LEN_WIDTH        = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   write_address,
  input  logic [C_LEN_WIDTH-1:0]          write_beats,
  input  logic                            start_write,
  output logic                            output_idle,
  output logic                            write_done,
  output logic                            write_error,
  output logic                            tlast_mismatch,
  input  logic [C_AXI_DATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic                            S_AXIS_TVALID,
  input  logic                            S_AXIS_TLAST,
  output logic                            S_AXIS_TREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY
);

  localparam int BYTES = C_AXI_DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int ALIGN = $clog2(C_M_AXI_BURST_LEN * BYTES);
  // Start address is aligned to a full burst so no burst can straddle a 4KB boundary.
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
    ~C_M_AXI_ADDR_WIDTH'((64'd1 << ALIGN) - 64'd1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_LEN_WIDTH-1:0]        remaining_q, remaining_d;
  logic [7:0]                    awlen_q, awlen_d;
  logic [7:0]                    beat_cnt_q, beat_cnt_d;
  logic                          write_error_q, write_error_d;
  logic                          tlast_mismatch_q, tlast_mismatch_d;

  logic [8:0] burst_beats;
  logic       w_hs;
  logic       final_beat;

  function automatic logic [7:0] burst_len_m1(input logic [C_LEN_WIDTH-1:0] rem);
    if (32'(rem) >= 32'(C_M_AXI_BURST_LEN)) return 8'(C_M_AXI_BURST_LEN - 1);
    return 8'(rem - C_LEN_WIDTH'(1));
  endfunction

  assign burst_beats = {1'b0, awlen_q} + 9'd1;
  assign w_hs        = (state_q == S_DATA) && S_AXIS_TVALID && M_AXI_WREADY;
  assign final_beat  = M_AXI_WLAST && (remaining_q == C_LEN_WIDTH'(burst_beats));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q          <= S_IDLE;
      addr_q           <= '0;
      remaining_q      <= '0;
      awlen_q          <= '0;
      beat_cnt_q       <= '0;
      write_error_q    <= 1'b0;
      tlast_mismatch_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      remaining_q      <= remaining_d;
      awlen_q          <= awlen_d;
      beat_cnt_q       <= beat_cnt_d;
      write_error_q    <= write_error_d;
      tlast_mismatch_q <= tlast_mismatch_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    remaining_d      = remaining_q;
    awlen_d          = awlen_q;
    beat_cnt_d       = beat_cnt_q;
    write_error_d    = write_error_q;
    tlast_mismatch_d = tlast_mismatch_q;
    case (state_q)
      S_IDLE: begin
        if (start_write) begin
          write_error_d    = 1'b0;
          tlast_mismatch_d = 1'b0;
          if (write_beats != '0) begin
            addr_d      = write_address & ALIGN_MASK;
            remaining_d = write_beats;
            awlen_d     = burst_len_m1(write_beats);
            state_d     = S_ADDR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ADDR: begin
        if (M_AXI_AWREADY) begin
          beat_cnt_d = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // TLAST must be high exactly on the last beat of the whole transfer.
          if (S_AXIS_TLAST != final_beat) tlast_mismatch_d = 1'b1;
          if (M_AXI_WLAST) state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) write_error_d = 1'b1;
          addr_d      = addr_q + (C_M_AXI_ADDR_WIDTH'(burst_beats) << SIZE);
          remaining_d = remaining_q - C_LEN_WIDTH'(burst_beats);
          if (remaining_d == '0) begin
            state_d = S_DONE;
          end else begin
            awlen_d = burst_len_m1(remaining_d);
            state_d = S_ADDR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign output_idle    = (state_q == S_IDLE);
  assign write_done     = (state_q == S_DONE);
  assign write_error    = write_error_q;
  assign tlast_mismatch = tlast_mismatch_q;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = awlen_q;
  assign M_AXI_AWSIZE  = 3'(SIZE);
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWVALID = (state_q == S_ADDR);

  assign M_AXI_WDATA   = S_AXIS_TDATA;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = (beat_cnt_q == awlen_q);
  assign M_AXI_WVALID  = (state_q == S_DATA) && S_AXIS_TVALID;
  assign S_AXIS_TREADY = (state_q == S_DATA) && M_AXI_WREADY;

  assign M_AXI_BREADY  = (state_q == S_RESP);

endmodule

// File: doc/axi4_stream_to_full.md
Name: axi4_stream_to_full

Overview:
- Writer counterpart of the MM2S read path: accepts an AXI4-Stream slave input and writes it to memory through an AXI4 memory-mapped master write channel.
- Transfers are started by a control pulse giving a start address and a beat count.
- The total beat count is split into INCR bursts of at most C_M_AXI_BURST_LEN beats.
- Implements AW/W/B directly with one FSM; read channel not present.

Parameters:
C_AXI_DATA_WIDTH, 32, data width of stream and AXI-MM (bits, power of 2, >=32)
C_M_AXI_ADDR_WIDTH, 32, AXI address width
C_M_AXI_BURST_LEN, 16, max beats per burst (4..256, power of 2)
C_M_AXI_ID_WIDTH, 1, AWID width (AWID driven 0)
C_LEN_WIDTH, 16, width of write_beats

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
write_address  in  C_M_AXI_ADDR_WIDTH  byte start address, sampled on start
write_beats  in  C_LEN_WIDTH  total beats to write, sampled on start
start_write  in  1  start pulse, honoured only in IDLE
output_idle  out  1  high in IDLE
write_done  out  1  one-cycle pulse at transfer end
write_error  out  1  sticky: any BRESP != OKAY; cleared on next accepted start
tlast_mismatch  out  1  sticky: TLAST position disagreed with write_beats; cleared on next accepted start
S_AXIS_TDATA  in  C_AXI_DATA_WIDTH  stream data
S_AXIS_TVALID  in  1  stream valid
S_AXIS_TLAST  in  1  stream last
S_AXIS_TREADY  out  1  stream ready
M_AXI_AWID/AWADDR/AWLEN[8]/AWSIZE[3]/AWBURST[2]/AWVALID  out  AXI4 write address
M_AXI_AWREADY  in  1
M_AXI_WDATA/WSTRB/WLAST/WVALID  out  AXI4 write data
M_AXI_WREADY  in  1
M_AXI_BRESP  in  2;  M_AXI_BVALID  in  1;  M_AXI_BREADY  out  1

Behaviour:
- Reset (async): state IDLE. AWVALID, WVALID, BREADY, S_AXIS_TREADY, write_done, write_error and tlast_mismatch all 0. output_idle 1. Counters and address 0.
- Constants:
  - AWSIZE = log2(C_AXI_DATA_WIDTH/8); AWBURST = 01 (INCR); AWID = 0; WSTRB all ones.
  - Low address bits below burst size (BURST_LEN*bytes) forced to 0, so no burst crosses 4KB.
- IDLE:
  - start_write && write_beats != 0: latch address and remaining = write_beats; clear sticky flags; go ADDR.
  - start_write && write_beats == 0: go DONE; no AXI traffic.
- ADDR:
  - AWVALID = 1.
  - AWLEN = min(remaining, BURST_LEN) - 1, computed on entry and held stable while AWVALID.
  - AWREADY: AWVALID drops next cycle; beat_cnt = 0; go DATA.
  - No AW/W overlap; W starts only after AW is accepted.
- DATA:
  - Pass-through, combinational:
    - WVALID = S_AXIS_TVALID
    - S_AXIS_TREADY = M_AXI_WREADY
    - WDATA = S_AXIS_TDATA
    - WLAST = (beat_cnt == AWLEN)
  - Each beat where TVALID && WREADY: beat_cnt++.
  - tlast_mismatch set if TLAST == 1 on a beat that is not the transfer's final beat, or TLAST == 0 on the final beat.
  - Handshake with WLAST: go RESP.
- RESP:
  - BREADY = 1.
  - On BVALID:
    - BRESP != 00 sets write_error.
    - address += (AWLEN+1)*bytes; remaining -= AWLEN+1.
    - remaining == 0: go DONE; else go ADDR.
- DONE: write_done = 1 for exactly one cycle; go IDLE.
- Outside DATA: S_AXIS_TREADY = 0 and WVALID = 0. Stream data is never dropped or duplicated.
- start_write outside IDLE: ignored.
- Backpressure: no required latency. Stalls on TVALID or WREADY at any beat are legal.
- Errors never abort a transfer; all beats are written.
- Address wrap at 2^C_M_AXI_ADDR_WIDTH is modular.
- ARESET mid-transfer: all valids drop immediately. The slave must be reset together with this block.

Test Plan:
- addr 0x1000, beats 16, BURST 16, TLAST on beat 16, WREADY/TVALID always 1 -> one AW (AWADDR 0x1000, AWLEN 15), 16 W beats with WLAST on the 16th, BREADY; write_done pulses once; both flags 0.
- addr 0x2000, beats 40 -> AWs at 0x2000/0x2040/0x2080 with AWLEN 15/15/7; data order preserved.
- Random TVALID and WREADY gaps, beats 37 -> 37 beats written, no duplicates, WLAST only on burst ends.
- Second BRESP = 10 in a 3-burst transfer -> write_error = 1 after it; transfer completes; next start clears the flag.
- TLAST on beat 5 of 8 -> tlast_mismatch = 1; all 8 beats still written.
- beats 0 -> write_done one cycle later, no AWVALID. ARESET asserted in DATA -> all outputs return to reset values asynchronously.
